// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared constants and types for the AES IV/counter register.
//   SP2V_HIGH / SP2V_LOW : the two legal codes of a 3-bit sparse write enable
//   NumSlicesCtr         : number of 16-bit slices in the 128-bit IV
//   SliceSizeCtr         : bits per slice
//   aes_iv_reg_state_e   : sparse FSM state encodings (pairwise distance >= 3)
// -----------------------------------------------------------------------------
package aes_pkg;

   localparam int Sp2VWidth    = 3;
   localparam int NumSlicesCtr = 8;
   localparam int SliceSizeCtr = 16;
   localparam int IvWidth      = NumSlicesCtr * SliceSizeCtr;

   localparam logic [Sp2VWidth-1:0] SP2V_HIGH = 3'b011;
   localparam logic [Sp2VWidth-1:0] SP2V_LOW  = 3'b100;

   // Minimum pairwise Hamming distance between these codes is 3, so a
   // single or double upset cannot turn one legal state into another.
   typedef enum logic [4:0] {
      IV_IDLE  = 5'b01110,
      IV_CLEAR = 5'b11101,
      IV_ACK   = 5'b00011,
      IV_ERROR = 5'b10000
   } aes_iv_reg_state_e;

   function automatic logic sp2v_valid(input logic [Sp2VWidth-1:0] code);
      return (code == SP2V_HIGH) || (code == SP2V_LOW);
   endfunction

endpackage

// File: rtl/aes_iv_slice.sv
// -----------------------------------------------------------------------------
// aes_iv_slice
// One 16-bit slice of the IV plus its "written by software" flag.
// Write priority: clear (prd) > counter update > software write.
// A software strobe sets the flag even when the counter wins the data mux.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clr             load prd_data and drop the flag
//   ctr_we, ctr_data  counter update (already decoded from sparse form)
//   sw_we, sw_data    software write
//   prd_data        pseudo-random clear value
//   data            registered slice value
//   written         registered written flag
// -----------------------------------------------------------------------------
module aes_iv_slice
   import aes_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    ctr_we,
   input  logic [SliceSizeCtr-1:0] ctr_data,
   input  logic                    sw_we,
   input  logic [SliceSizeCtr-1:0] sw_data,
   input  logic [SliceSizeCtr-1:0] prd_data,
   output logic [SliceSizeCtr-1:0] data,
   output logic                    written
);

   always_ff @(posedge clk) begin
      if (rst) begin
         data    <= '0;
         written <= 1'b0;
      end else begin
         if (clr) begin
            data <= prd_data;
         end else if (ctr_we) begin
            data <= ctr_data;
         end else if (sw_we) begin
            data <= sw_data;
         end

         if (clr) begin
            written <= 1'b0;
         end else if (sw_we) begin
            written <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/aes_iv_reg.sv
// -----------------------------------------------------------------------------
// aes_iv_reg
// 128-bit IV/counter register for the AES core, built from eight 16-bit
// slices. Accepts counter updates (sparse per-slice enables), software writes
// and pseudo-random clear requests; raises a sticky fatal alert on any
// illegal sparse enable code.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   sw_data_i, sw_we_i  software write data / per-slice strobes
//   ctr_i, ctr_we_i     counter value / sparse per-slice enables (3 bits each)
//   clear_i, prd_i      clear request (level, held until ack) / random data
//   clear_ack_o         one-cycle clear acknowledge
//   iv_o                registered IV
//   iv_valid_o          all slices written by software since clear/reset
//   alert_o             fatal alert, sticky until reset
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IV_IDLE  | normal operation: counter and software writes applied
// IV_CLEAR | load all slices from prd_i, drop written flags
// IV_ACK   | pulse clear_ack_o, writes ignored
// IV_ERROR | terminal: alert_o high, everything frozen until reset
// -----------------------------------------------------------------------------
module aes_iv_reg
   import aes_pkg::*;
(
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [IvWidth-1:0]               sw_data_i,
   input  logic [NumSlicesCtr-1:0]          sw_we_i,
   input  logic [IvWidth-1:0]               ctr_i,
   input  logic [NumSlicesCtr*Sp2VWidth-1:0] ctr_we_i,
   input  logic                             clear_i,
   input  logic [IvWidth-1:0]               prd_i,
   output logic                             clear_ack_o,
   output logic [IvWidth-1:0]               iv_o,
   output logic                             iv_valid_o,
   output logic                             alert_o
);

   aes_iv_reg_state_e state_q, state_d;

   logic                    sp2v_err;
   logic                    wr_allow;
   logic                    clr_slices;
   logic [NumSlicesCtr-1:0] ctr_we_dec;
   logic [NumSlicesCtr-1:0] sw_we_gated;
   logic [NumSlicesCtr-1:0] written;

   // Sparse enable check runs regardless of state.
   always_comb begin
      sp2v_err   = 1'b0;
      ctr_we_dec = '0;
      for (int k = 0; k < NumSlicesCtr; k++) begin
         if (!sp2v_valid(ctr_we_i[Sp2VWidth*k +: Sp2VWidth])) begin
            sp2v_err = 1'b1;
         end
         ctr_we_dec[k] = (ctr_we_i[Sp2VWidth*k +: Sp2VWidth] == SP2V_HIGH);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IV_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IV_IDLE:  state_d = clear_i ? IV_CLEAR : IV_IDLE;
         IV_CLEAR: state_d = IV_ACK;
         IV_ACK:   state_d = IV_IDLE;
         IV_ERROR: state_d = IV_ERROR;
         default:  state_d = IV_ERROR;
      endcase
      if (sp2v_err) begin
         state_d = IV_ERROR;
      end
   end

   // An illegal code anywhere suppresses every write in that cycle, even to
   // slices whose own enable was legal.
   always_comb begin
      wr_allow    = (state_q == IV_IDLE)  && !sp2v_err;
      clr_slices  = (state_q == IV_CLEAR) && !sp2v_err;
      clear_ack_o = (state_q == IV_ACK);
      alert_o     = (state_q == IV_ERROR);
      sw_we_gated = wr_allow ? sw_we_i    : '0;
   end

   for (genvar k = 0; k < NumSlicesCtr; k++) begin : g_slice
      aes_iv_slice u_slice (
         .clk      (clk_i),
         .rst      (rst_i),
         .clr      (clr_slices),
         .ctr_we   (wr_allow & ctr_we_dec[k]),
         .ctr_data (ctr_i[SliceSizeCtr*k +: SliceSizeCtr]),
         .sw_we    (sw_we_gated[k]),
         .sw_data  (sw_data_i[SliceSizeCtr*k +: SliceSizeCtr]),
         .prd_data (prd_i[SliceSizeCtr*k +: SliceSizeCtr]),
         .data     (iv_o[SliceSizeCtr*k +: SliceSizeCtr]),
         .written  (written[k])
      );
   end

   assign iv_valid_o = &written;

endmodule
